shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 100 ++++++++++
 1 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier: one shift-and-add step per cycle through an
// external 2N-bit adder. A result takes exactly N RUN cycles, then a one-cycle DONE.
module shift_add_multiplier #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] add_a,
  output logic [2*N-1:0] add_b,
  input  logic [2*N-1:0] add_sum,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [1:0]     dbg_state
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [2*N-1:0] r_mreg;
  logic [N-1:0]   r_qreg;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_product;
  logic           r_busy;
  logic           r_done;

  logic           w_run;
  logic           w_last;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == CW'(N - 1));

  // The adder sees zeros outside RUN so its output is quiet between operations.
  assign add_a = w_run ? r_acc : '0;
  assign add_b = (w_run && r_qreg[0]) ? r_mreg : '0;

  assign busy      = r_busy;
  assign done      = r_done;
  assign product   = r_product;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mreg    <= '0;
      r_qreg    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mreg  <= {{N{1'b0}}, a};
            r_qreg  <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc  <= add_sum;
          r_mreg <= r_mreg << 1;
          r_qreg <= r_qreg >> 1;
          r_cnt  <= r_cnt + CW'(1);
          // The final partial sum goes straight into product on the same edge.
          if (w_last) begin
            r_product <= add_sum;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
